hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//   Producer-side reservation table for the pipelined MIPS core. Records the destination register
//   and result latency of each instruction leaving ID, then counts down until that result is
//   available on a forwarding path. Raises stall when the instruction in ID reads a register whose
//   producer's result is not yet forwardable (load-use, multi-cycle ops).
//   Complements the EX-stage forwarding selects: forwarding consumes ready results; this unit holds
//   off consumers until results are ready.
// PARAMETERS
//   NUM_REGS   32   architectural registers; r0 is never reserved
//   LAT_W      3    width of latency field / per-register counter (max latency 2^LAT_W-1)
//   CNT_W      16   width of stall-cycle performance counter
// PORTS
//   clk              in   1          core clock
//   rst              in   1          synchronous reset, active-high
//   id_rs            in   5          source register rs of instruction in ID
//   id_rt            in   5          source register rt of instruction in ID
//   id_use_rs        in   1          instruction in ID reads rs
//   id_use_rt        in   1          instruction in ID reads rt
//   issue_valid      in   1          instruction in ID is valid and wants to advance to EX
//   issue_reg_write  in   1          instruction in ID writes a register
//   issue_rd         in   5          destination register of instruction in ID
//   issue_latency    in   LAT_W      cycles after issue before result is forwardable (0 = ALU op)
//   flush            in   1          instruction in ID is wrong-path; must not be recorded
//   stall            out  1          hold PC and IF/ID; insert bubble into ID/EX
//   pending_mask     out  NUM_REGS   bit r = 1 while cnt[r] != 0
//   stall_count      out  CNT_W      saturating count of cycles with stall = 1
// BEHAVIOUR
//   State: cnt[r], LAT_W bits, r = 1..NUM_REGS-1; cnt[0] hard-wired 0. stall_count register.
//   Reset (rst=1 at posedge): all cnt <= 0, stall_count <= 0. Hence stall=0, pending_mask=0 from
//     the first cycle after reset. Reset mid-operation discards all reservations, no residue.
//   stall (combinational, same cycle):
//     (id_use_rs && id_rs!=0 && cnt[id_rs]!=0) || (id_use_rt && id_rt!=0 && cnt[id_rt]!=0).
//     stall does not depend on issue_valid; downstream gates it.
//   issue_fire = issue_valid && !stall && !flush && issue_reg_write && issue_rd!=0 &&
//     issue_latency!=0.
//   Per-cycle update, each r:
//     dec = (cnt[r]!=0) ? cnt[r]-1 : 0
//     if issue_fire && issue_rd==r : cnt[r] <= max(issue_latency, dec)  (WAW: later-ready wins)
//     else                         : cnt[r] <= dec
//   Latency semantics: latency L -> consumer in ID during the next L cycles stalls; consumer in
//     ID at cycle L+1 proceeds (result reaches forwarding path). lw uses L=1 (one bubble).
//   Stalled or flushed instruction records nothing; it is re-presented when stall drops.
//   Source == own destination (e.g. addi $8,$8,1): check uses cnt before this issue; no self-stall.
//   stall_count: +1 each cycle stall=1; saturates at 2^CNT_W-1, never wraps.
//   pending_mask[r] = (cnt[r]!=0); bit 0 always 0. All outputs derive from registered state plus
//     ID inputs; no combinational path from issue_* to stall.
// TESTING
//   1 Reset: rst=1 one cycle, all inputs 0 -> stall=0, pending_mask=0, stall_count=0.
//   2 Load-use: issue rd=8 lat=1; next cycle id_rs=8 use_rs=1 -> stall=1 one cycle, then 0;
//     stall_count=1; pending_mask[8] high exactly one cycle.
//   3 r0 / ALU: issue rd=0 lat=3, then rd=9 lat=0; read rs=0, rt=9 -> stall=0 throughout,
//     pending_mask=0.
//   4 WAW: issue rd=5 lat=4, next cycle rd=5 lat=1 -> cnt[5]=3 (max(1,3)); consumer of $5 stalls
//     3 cycles; pending_mask[5] clears on the 5th cycle after the first issue.
//   5 Flush/stall gating: issue rd=7 lat=2 with flush=1 -> no reservation; issue rd=7 while
//     stall=1 (rs hazard) -> not recorded until stall drops.
//   6 Reset mid-op: reserve rd=3 lat=7, 2 cycles later rst=1 -> pending_mask=0, stall=0 next cycle;
//     stall_count forced to 2^CNT_W-1 (CNT_W=4 build) holds at 15 under continued stall.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-register result-latency reservation table; raises stall when ID reads a not-yet-forwardable register.
// Latency: stall is combinational from ID inputs and registered counters; reservations land one cycle after issue. No backpressure input.
module hazard_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int LAT_W    = 3,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4:0]          id_rs,
   input  logic [4:0]          id_rt,
   input  logic                id_use_rs,
   input  logic                id_use_rt,
   input  logic                issue_valid,
   input  logic                issue_reg_write,
   input  logic [4:0]          issue_rd,
   input  logic [LAT_W-1:0]    issue_latency,
   input  logic                flush,
   output logic                stall,
   output logic [NUM_REGS-1:0] pending_mask,
   output logic [CNT_W-1:0]    stall_count
);

   logic [LAT_W-1:0] cnt     [NUM_REGS];
   logic [LAT_W-1:0] cnt_nxt [NUM_REGS];
   logic             rs_hazard;
   logic             rt_hazard;
   logic             issue_fire;

   function automatic logic [LAT_W-1:0] count_down(input logic [LAT_W-1:0] c);
      return (c != '0) ? c - LAT_W'(1) : '0;
   endfunction

   // Hazard check reads counters as they stand before this cycle's issue, so a
   // source that equals its own destination never self-stalls.
   always_comb begin
      rs_hazard  = id_use_rs && (id_rs != 5'd0) && (cnt[id_rs] != '0);
      rt_hazard  = id_use_rt && (id_rt != 5'd0) && (cnt[id_rt] != '0);
      stall      = rs_hazard || rt_hazard;
      issue_fire = issue_valid && !stall && !flush && issue_reg_write &&
                   (issue_rd != 5'd0) && (issue_latency != '0);
   end

   // WAW: a newer reservation never shortens an older, later-ready one.
   always_comb begin
      cnt_nxt[0] = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         cnt_nxt[r] = count_down(cnt[r]);
         if (issue_fire && (issue_rd == 5'(r)) && (issue_latency > cnt_nxt[r])) begin
            cnt_nxt[r] = issue_latency;
         end
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         pending_mask[r] = (cnt[r] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt[r] <= '0;
         end
         stall_count <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt[r] <= cnt_nxt[r];
         end
         if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
         end
      end
   end

endmodule
